// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM block.
package pwm_pkg;

  localparam int unsigned DEF_RES      = 8;
  localparam int unsigned DEF_CHANNELS = 4;

  // Channel-index width, never narrower than one bit.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: active pulsewidth register, optional slew limiting, compare and output flop.
// Slew limiting is enabled by defining PWM_MULTI_SLEW_EN.
module pwm_chan
  import pwm_pkg::*;
#(
  parameter int unsigned RES       = DEF_RES,
  parameter int unsigned SLEW_STEP = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           run,
  input  logic [RES-1:0] cnt,
  input  logic [RES-1:0] shadow_pw,
  output logic           pwm
);

`ifdef PWM_MULTI_SLEW_EN
  localparam bit SLEW_ON = 1'b1;
`else
  localparam bit SLEW_ON = 1'b0;
`endif

  // A full-range step lands on the shadow value in one load, i.e. a direct copy.
  localparam int unsigned STEP_MAX = (32'(1) << RES) - 1;
  localparam int unsigned STEP_LIM = !SLEW_ON ? STEP_MAX :
                                     ((SLEW_STEP < STEP_MAX) ? SLEW_STEP : STEP_MAX);
  localparam logic [RES-1:0] STEP  = RES'(STEP_LIM);

  logic [RES-1:0] act_pw;
  logic [RES-1:0] act_pw_next;

  always_comb begin
    act_pw_next = shadow_pw;
    if ((shadow_pw > act_pw) && ((shadow_pw - act_pw) > STEP)) begin
      act_pw_next = act_pw + STEP;
    end else if ((act_pw > shadow_pw) && ((act_pw - shadow_pw) > STEP)) begin
      act_pw_next = act_pw - STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_pw <= '0;
      pwm    <= 1'b0;
    end else begin
      if (load) begin
        act_pw <= act_pw_next;
      end
      pwm <= run & (cnt < act_pw);
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared period counter, pulsewidth write handshake and per-channel outputs.
// Optional slew limiting of pulsewidth updates is enabled by defining PWM_MULTI_SLEW_EN.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int unsigned CHANNELS  = DEF_CHANNELS,
  parameter int unsigned RES       = DEF_RES,
  parameter int unsigned SLEW_STEP = 1,
  localparam int unsigned CH_W     = ch_idx_w(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [RES-1:0]      period,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [RES-1:0]      wr_pw,
  output logic                wr_err,
  output logic                period_start,
  output logic [CHANNELS-1:0] pwm_sig
);

  logic [RES-1:0] cnt;
  logic [RES-1:0] act_period;
  logic [RES-1:0] shadow_pw [CHANNELS];
  logic           rdy_q;

  logic running_c;
  logic boundary_c;
  logic load_c;
  logic xfer_c;
  logic ch_ok_c;

  // Stopped (en low or zero period) behaves like a permanent boundary: shadows copy every cycle.
  assign running_c  = en & (act_period != '0);
  assign boundary_c = running_c & (cnt == (act_period - RES'(1)));
  assign load_c     = ~running_c | boundary_c;

  assign wr_ready = rdy_q & ~boundary_c;
  assign xfer_c   = wr_valid & wr_ready;
  assign ch_ok_c  = ({1'b0, wr_ch} < (CH_W + 1)'(CHANNELS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      act_period   <= '0;
      rdy_q        <= 1'b0;
      wr_err       <= 1'b0;
      period_start <= 1'b0;
    end else begin
      rdy_q        <= 1'b1;
      wr_err       <= xfer_c & ~ch_ok_c;
      period_start <= running_c & (cnt == '0);
      cnt          <= (running_c & ~boundary_c) ? cnt + RES'(1) : '0;
      if (load_c) begin
        act_period <= period;
      end
    end
  end

  // Out-of-range channel writes complete the handshake but touch no shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        shadow_pw[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (xfer_c && ch_ok_c && (wr_ch == CH_W'(i))) begin
          shadow_pw[i] <= wr_pw;
        end
      end
    end
  end

  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_chan
    pwm_chan #(
      .RES       (RES),
      .SLEW_STEP (SLEW_STEP)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load_c),
      .run       (running_c),
      .cnt       (cnt),
      .shadow_pw (shadow_pw[g]),
      .pwm       (pwm_sig[g])
    );
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: vector table, directed corner sequences, randomized run vs model.
module tb_pwm_multi;

  localparam int unsigned NCH  = 6;
  localparam int unsigned W    = 6;
  localparam int unsigned CHW  = 3;
  localparam int unsigned STEP = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic [W-1:0]   period;
  logic           wr_valid;
  logic           wr_ready;
  logic [CHW-1:0] wr_ch;
  logic [W-1:0]   wr_pw;
  logic           wr_err;
  logic           period_start;
  logic [NCH-1:0] pwm_sig;

  always #5 clk = ~clk;

  pwm_multi #(.CHANNELS(NCH), .RES(W), .SLEW_STEP(STEP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .period       (period),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_ch        (wr_ch),
    .wr_pw        (wr_pw),
    .wr_err       (wr_err),
    .period_start (period_start),
    .pwm_sig      (pwm_sig)
  );

  int total = 0;
  int bad   = 0;

  // Reference state: period position, applied period and per-channel pulsewidths.
  int             m_pos;
  int             m_per;
  int             m_act [NCH];
  int             m_sh  [NCH];
  bit             m_rdy;
  logic [NCH-1:0] m_pwm;
  bit             m_ps;
  bit             m_err;
  bit             last_xfer;
  int             acc       [NCH];
  int             last_high [NCH];

  typedef struct {
    int per;
    int pw;
    int win;
    int exp_hi;
    int exp_ps;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int slew_to(input int a, input int s);
`ifdef PWM_MULTI_SLEW_EN
    if (s > a + int'(STEP)) return a + int'(STEP);
    if (s + int'(STEP) < a) return a - int'(STEP);
    return s;
`else
    return s;
`endif
  endfunction

  task automatic model_reset();
    m_pos = 0; m_per = 0; m_rdy = 1'b0; m_pwm = '0; m_ps = 1'b0; m_err = 1'b0;
    for (int i = 0; i < int'(NCH); i++) begin
      m_act[i] = 0; m_sh[i] = 0; acc[i] = 0; last_high[i] = 0;
    end
  endtask

  // One clock: check ready before the edge, advance the reference, compare registered outputs after.
  task automatic cycle();
    bit run, at_end, rdy;
    #1;
    run    = en && (m_per != 0);
    at_end = run && (m_pos == m_per - 1);
    rdy    = m_rdy && !at_end;
    check("wr_ready", int'(wr_ready), int'(rdy));
    @(posedge clk);
    last_xfer = wr_valid && rdy;
    m_err = last_xfer && (int'(wr_ch) >= int'(NCH));
    m_ps  = run && (m_pos == 0);
    for (int i = 0; i < int'(NCH); i++) m_pwm[i] = run && (m_pos < m_act[i]);
    if (!run || at_end) begin
      for (int i = 0; i < int'(NCH); i++) m_act[i] = slew_to(m_act[i], m_sh[i]);
      m_per = int'(period);
    end
    if (last_xfer && (int'(wr_ch) < int'(NCH))) m_sh[wr_ch] = int'(wr_pw);
    m_pos = (run && !at_end) ? m_pos + 1 : 0;
    m_rdy = 1'b1;
    #1;
    check("pwm_sig", int'(pwm_sig), int'(m_pwm));
    check("period_start", int'(period_start), int'(m_ps));
    check("wr_err", int'(wr_err), int'(m_err));
    for (int i = 0; i < int'(NCH); i++) begin
      if (period_start === 1'b1) begin
        last_high[i] = acc[i];
        acc[i] = int'(pwm_sig[i]);
      end else begin
        acc[i] += int'(pwm_sig[i]);
      end
    end
  endtask

  task automatic write_one(input int ch, input int pw);
    bit done = 1'b0;
    wr_valid = 1'b1; wr_ch = CHW'(ch); wr_pw = W'(pw);
    for (int k = 0; k < 50 && !done; k++) begin
      cycle();
      done = last_xfer;
    end
    wr_valid = 1'b0;
    if (!done) check("write_timeout", 0, 1);
  endtask

  task automatic wait_ps();
    bit seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      cycle();
      seen = (period_start === 1'b1);
    end
    if (!seen) check("period_start_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   hi, ps;
    int   exp_slew [3];

    vecs[0] = '{per: 32, pw: 25, win: 64, exp_hi: 50, exp_ps: 2};
    vecs[1] = '{per: 32, pw: 0,  win: 64, exp_hi: 0,  exp_ps: 2};
    vecs[2] = '{per: 32, pw: 40, win: 64, exp_hi: 64, exp_ps: 2};
    vecs[3] = '{per: 7,  pw: 3,  win: 14, exp_hi: 6,  exp_ps: 2};
    vecs[4] = '{per: 1,  pw: 1,  win: 2,  exp_hi: 2,  exp_ps: 2};
    vecs[5] = '{per: 1,  pw: 0,  win: 2,  exp_hi: 0,  exp_ps: 2};
    vecs[6] = '{per: 0,  pw: 5,  win: 20, exp_hi: 0,  exp_ps: 0};
    vecs[7] = '{per: 5,  pw: 5,  win: 10, exp_hi: 10, exp_ps: 2};
`ifdef PWM_MULTI_SLEW_EN
    exp_slew = '{4, 8, 10};
`else
    exp_slew = '{10, 10, 10};
`endif

    rst_n = 1'b0; en = 1'b0; period = '0; wr_valid = 1'b0; wr_ch = '0; wr_pw = '0;
    #1;
    check("rst_wr_ready", int'(wr_ready), 0);
    check("rst_pwm_sig", int'(pwm_sig), 0);
    check("rst_period_start", int'(period_start), 0);
    check("rst_wr_err", int'(wr_err), 0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    cycle();

    // Vector table on channel 0: highs and period starts over exactly two periods.
    for (int v = 0; v < 8; v++) begin
      en = 1'b0;
      period = W'(vecs[v].per);
      write_one(0, vecs[v].pw);
      idle(20);
      en = 1'b1;
      hi = 0; ps = 0;
      for (int k = 0; k < vecs[v].win; k++) begin
        cycle();
        hi += int'(pwm_sig[0]);
        ps += int'(period_start);
      end
      check($sformatf("vec%0d_high", v), hi, vecs[v].exp_hi);
      check($sformatf("vec%0d_pstart", v), ps, vecs[v].exp_ps);
    end

    // Mid-period write takes effect only from the following period.
    en = 1'b0; period = W'(32);
    write_one(1, 20);
    write_one(2, 3);
    idle(20);
    en = 1'b1;
    wait_ps();
    idle(5);
    write_one(1, 10);
    wait_ps();
    check("midwr_cur_period", last_high[1], 20);
    wait_ps();
    check("midwr_next_period", last_high[1], slew_to(20, 10));

    // Write presented on the boundary cycle stalls one cycle.
    idle(30);
    wr_valid = 1'b1; wr_ch = CHW'(2); wr_pw = W'(9);
    #1;
    check("bnd_wr_ready", int'(wr_ready), 0);
    cycle();
    check("bnd_stall", int'(last_xfer), 0);
    #1;
    check("post_bnd_wr_ready", int'(wr_ready), 1);
    cycle();
    check("post_bnd_xfer", int'(last_xfer), 1);
    wr_valid = 1'b0;
    wait_ps();
    check("bnd_wr_cur_period", last_high[2], 3);
    wait_ps();
    check("bnd_wr_next_period", last_high[2], slew_to(3, 9));

    // Out-of-range channel: error pulse only.
    idle(3);
    write_one(7, 33);
    check("bad_ch_err", int'(wr_err), 1);
    cycle();
    check("bad_ch_err_clear", int'(wr_err), 0);

    // Pulsewidth 0 -> 10 on channel 3, observed per period.
    en = 1'b0;
    write_one(3, 0);
    idle(20);
    en = 1'b1;
    wait_ps();
    write_one(3, 10);
    wait_ps();
    for (int p = 0; p < 3; p++) begin
      wait_ps();
      check($sformatf("slew_period%0d", p), last_high[3], exp_slew[p]);
    end

    // Asynchronous reset mid-period drops outputs before any clock edge.
    wait_ps();
    idle(3);
    check("pre_rst_ch3_high", int'(pwm_sig[3]), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_pwm", int'(pwm_sig), 0);
    check("async_rst_ready", int'(wr_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    en = 1'b1; wr_valid = 1'b0;
    rst_n = 1'b1;
    idle(40);
    check("post_rst_shadows_cleared", int'(pwm_sig), 0);

    // Randomized traffic against the reference.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 30) == 0) period = W'($urandom_range(0, 12));
      en       = ($urandom_range(0, 15) != 0);
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_ch    = CHW'($urandom_range(0, 7));
      wr_pw    = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 12)) : W'($urandom_range(0, 63));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
